// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [2:0] {IDLE, CLR, WR, MAC, DRAIN, DONE} fir_seq_state_t;

  localparam int unsigned FIR_TAPS_MAX = 64;
  localparam int unsigned FIR_AW_MAX   = $clog2(FIR_TAPS_MAX);

  // Circular tap address (ptr - k) folded into the active ring size via mask.
  function automatic logic [FIR_AW_MAX-1:0] fir_circ_addr(
    input logic [FIR_AW_MAX-1:0] ptr,
    input logic [FIR_AW_MAX-1:0] k,
    input logic [FIR_AW_MAX-1:0] mask
  );
    return (ptr - k) & mask;
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Loadable up-counter with terminal-count flag; walks taps during MAC and CLR.
module fir_tap_counter #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          tc_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + AW'(1);
    end
  end

  assign tc_c = (cnt == {AW{1'b1}});

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control unit for a single-MAC serial FIR: sample write, tap walk, drain,
// result strobe, and a deferred software clear of the sample RAM.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int unsigned TAPS    = 8,
  parameter  int unsigned MAC_LAT = 2,
  localparam int unsigned AW      = $clog2(TAPS)
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sw_clear,
  output logic          ram_we,
  output logic          ram_wsel0,
  output logic [AW-1:0] ram_addr,
  output logic [AW-1:0] rom_addr,
  output logic          mac_init,
  output logic          mac_en,
  output logic          out_valid,
  output logic          busy
);

  localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fir_seq_state_t state_q, state_d;
  logic [AW-1:0]  wr_ptr_q;
  logic [DW-1:0]  drain_cnt_q;
  logic           clr_pend_q;
  logic [AW-1:0]  k_c;
  logic           k_tc_c;
  logic           k_load_c;

  // Tap index runs only while walking MAC or CLR; parked at zero otherwise.
  assign k_load_c = (state_q != MAC) && (state_q != CLR);

  fir_tap_counter #(.AW(AW)) u_tap_counter (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .load  (k_load_c),
    .en    (!k_load_c),
    .cnt   (k_c),
    .tc_c  (k_tc_c)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A pending or fresh clear always beats a waiting sample in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sw_clear || clr_pend_q) state_d = CLR;
               else if (in_valid)          state_d = WR;
      CLR:     if (k_tc_c) state_d = IDLE;
      WR:      state_d = MAC;
      MAC:     if (k_tc_c) state_d = (MAC_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt_q == DW'(MAC_LAT - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write pointer, drain counter and deferred-clear flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q    <= '0;
      drain_cnt_q <= '0;
      clr_pend_q  <= 1'b0;
    end else begin
      if (state_q == DONE) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end else if ((state_q == CLR) && k_tc_c) begin
        wr_ptr_q <= '0;
      end
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DW'(1) : '0;
      if (state_q == IDLE) begin
        clr_pend_q <= 1'b0;
      end else if (sw_clear && (state_q != CLR)) begin
        clr_pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_wsel0 = 1'b0;
    ram_addr  = '0;
    rom_addr  = '0;
    mac_init  = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: in_ready = !sw_clear && !clr_pend_q;
      CLR: begin
        ram_we    = 1'b1;
        ram_wsel0 = 1'b1;
        ram_addr  = k_c;
      end
      WR: begin
        ram_we   = 1'b1;
        ram_addr = wr_ptr_q;
      end
      MAC: begin
        mac_en   = 1'b1;
        mac_init = (k_c == '0);
        rom_addr = k_c;
        ram_addr = AW'(fir_circ_addr(FIR_AW_MAX'(wr_ptr_q), FIR_AW_MAX'(k_c),
                                     FIR_AW_MAX'(TAPS - 1)));
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: behavioural sample RAM, ROM h = 1..8 and 2-stage MAC around the sequencer.
module tb_fir_mac_sequencer;

  localparam int unsigned TAPS = 8;
  localparam int unsigned LAT  = 12;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       in_valid = 1'b0;
  logic       sw_clear = 1'b0;
  logic       in_ready, ram_we, ram_wsel0, mac_init, mac_en, out_valid, busy;
  logic [2:0] ram_addr, rom_addr;

  int tests = 0;
  int fails = 0;

  fir_mac_sequencer #(.TAPS(8), .MAC_LAT(2)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sw_clear  (sw_clear),
    .ram_we    (ram_we),
    .ram_wsel0 (ram_wsel0),
    .ram_addr  (ram_addr),
    .rom_addr  (rom_addr),
    .mac_init  (mac_init),
    .mac_en    (mac_en),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  // Datapath model
  int ram [TAPS];
  int rom [TAPS];
  int in_data = 0;
  int s0_prod = 0;
  logic s0_init = 1'b0;
  logic s0_vld = 1'b0;
  int acc = 0;
  int cyc = 0;
  int last_acc = 0;

  int y_q[$];
  int lat_q[$];
  int acc_q[$];
  int wr_addr_q[$];
  int clr_addr_q[$];
  int busy_ready_err = 0;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (ram_we) ram[ram_addr] <= ram_wsel0 ? 0 : in_data;
    s0_vld <= mac_en;
    if (mac_en) begin
      s0_prod <= ram[ram_addr] * rom[rom_addr];
      s0_init <= mac_init;
    end
    if (s0_vld) acc <= s0_init ? s0_prod : acc + s0_prod;
    if (in_valid && in_ready) last_acc <= cyc;
  end

  always @(posedge ACLK) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid) begin
      y_q.push_back(acc);
      lat_q.push_back(cyc - last_acc);
    end
    if (ram_we && !ram_wsel0) wr_addr_q.push_back(int'(ram_addr));
    if (ram_we && ram_wsel0) clr_addr_q.push_back(int'(ram_addr));
    if (busy && in_ready) busy_ready_err++;
  end

  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    in_data = v;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
    end
    in_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_accept: got no accept, expected accept within 60 cycles");
    end
  endtask

  task automatic get_y(input string name, input int exp_y);
    bit ok;
    int y, lat;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (y_q.size() > 0) ok = 1'b1;
      else @(negedge ACLK);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: got no out_valid, expected y=%0d", name, exp_y);
    end else begin
      y = y_q.pop_front();
      lat = lat_q.pop_front();
      if (y !== exp_y) begin
        fails++;
        $display("FAIL %s_y: got %0d expected %0d", name, y, exp_y);
      end
      tests++;
      if (lat !== LAT) begin
        fails++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
      end
    end
  endtask

  task automatic do_clear();
    bit ok;
    clr_addr_q.delete();
    sw_clear = 1'b1;
    @(negedge ACLK);
    sw_clear = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (clr_addr_q.size() >= TAPS) ok = 1'b1;
      else @(negedge ACLK);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL clear_done: got %0d clear writes, expected %0d", clr_addr_q.size(), TAPS);
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    #200;
    tests++;
    if ({in_ready, busy, out_valid, ram_we} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_outputs: got rdy/busy/ov/we=%b expected 1000", {in_ready, busy, out_valid, ram_we});
    end
    tests++;
    if ({mac_en, mac_init, ram_wsel0, ram_addr, rom_addr} !== 9'd0) begin
      fails++;
      $display("FAIL reset_other: got %b expected 0", {mac_en, mac_init, ram_wsel0, ram_addr, rom_addr});
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_impulse();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 1 : 0);
      get_y("impulse", i + 1);
    end
  endtask

  task automatic test_wrap();
    int exp_y [10] = '{1, 3, 6, 10, 15, 21, 28, 36, 36, 36};
    do_clear();
    wr_addr_q.delete();
    for (int i = 0; i < 10; i++) begin
      send(1);
      get_y("wrap", exp_y[i]);
    end
    tests++;
    if (wr_addr_q.size() != 10) begin
      fails++;
      $display("FAIL wrap_writes: got %0d writes expected 10", wr_addr_q.size());
    end else begin
      tests++;
      if (wr_addr_q[8] !== 0) begin
        fails++;
        $display("FAIL wrap_addr9: got %0d expected 0", wr_addr_q[8]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    acc_q.delete();
    busy_ready_err = 0;
    in_data = 0;
    in_valid = 1'b1;
    repeat (60) @(negedge ACLK);
    in_valid = 1'b0;
    repeat (20) @(negedge ACLK);
    y_q.delete();
    lat_q.delete();
    tests++;
    if (acc_q.size() < 4) begin
      fails++;
      $display("FAIL bp_count: got %0d accepts expected at least 4", acc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (acc_q[i] - acc_q[i-1] !== LAT + 1) begin
          fails++;
          $display("FAIL bp_spacing: got %0d expected %0d", acc_q[i] - acc_q[i-1], LAT + 1);
        end
      end
    end
    tests++;
    if (busy_ready_err !== 0) begin
      fails++;
      $display("FAIL bp_ready_busy: got %0d busy&ready cycles expected 0", busy_ready_err);
    end
  endtask

  task automatic test_clear_collision();
    bit ok;
    do_clear();
    y_q.delete();
    lat_q.delete();
    send(1);
    repeat (3) @(negedge ACLK);
    tests++;
    if (mac_en !== 1'b1) begin
      fails++;
      $display("FAIL coll_in_mac: got mac_en=%b expected 1", mac_en);
    end
    clr_addr_q.delete();
    sw_clear = 1'b1;
    @(negedge ACLK);
    sw_clear = 1'b0;
    @(negedge ACLK);
    sw_clear = 1'b1;
    @(negedge ACLK);
    sw_clear = 1'b0;
    get_y("coll_current", 1);
    repeat (20) @(negedge ACLK);
    tests++;
    if (clr_addr_q.size() !== TAPS) begin
      fails++;
      $display("FAIL coll_clear_count: got %0d expected %0d", clr_addr_q.size(), TAPS);
    end else begin
      ok = 1'b1;
      for (int i = 0; i < TAPS; i++) if (clr_addr_q[i] != i) ok = 1'b0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL coll_clear_addr: got first=%0d last=%0d expected 0..7", clr_addr_q[0], clr_addr_q[TAPS-1]);
      end
    end
    wr_addr_q.delete();
    send(1);
    get_y("coll_next", 1);
    tests++;
    if (wr_addr_q.size() < 1 || wr_addr_q[0] !== 0) begin
      fails++;
      $display("FAIL coll_ptr_reset: got %0d writes, expected first write at address 0", wr_addr_q.size());
    end
  endtask

  task automatic test_simultaneous();
    y_q.delete();
    lat_q.delete();
    wr_addr_q.delete();
    sw_clear = 1'b1;
    in_valid = 1'b1;
    in_data = 7;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL sim_ready: got %b expected 0", in_ready);
    end
    @(negedge ACLK);
    sw_clear = 1'b0;
    in_valid = 1'b0;
    tests++;
    if ({busy, ram_we, ram_wsel0} !== 3'b111) begin
      fails++;
      $display("FAIL sim_clr_entry: got busy/we/wsel0=%b expected 111", {busy, ram_we, ram_wsel0});
    end
    repeat (20) @(negedge ACLK);
    tests++;
    if (wr_addr_q.size() !== 0 || y_q.size() !== 0) begin
      fails++;
      $display("FAIL sim_no_accept: got %0d writes %0d results expected 0 0", wr_addr_q.size(), y_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < TAPS; i++) rom[i] = i + 1;
    test_reset();
    test_impulse();
    test_wrap();
    test_backpressure();
    test_clear_collision();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
